// File: rtl/vga_text_scheduler.sv
// rtl/vga_text_scheduler.sv - font-ROM scheduler and text-on pipeline for the clock overlay labels
// Shadowed label glyph/blink registers commit at vblank entry; two-stage pixel pipeline.
module vga_text_scheduler #(
  parameter int CHAR_W  = 6,
  parameter int VB_LINE = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                video_on,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_slot,
  input  logic [CHAR_W-1:0]   cfg_char,
  input  logic                cfg_blink,
  output logic [CHAR_W+3:0]   rom_addr,
  input  logic [7:0]          rom_data,
  output logic                text_on,
  output logic [2:0]          text_slot,
  output logic                video_on_d,
  output logic [4:0]          frame_cnt
);

  localparam logic [2:0] NO_SLOT = 3'd7;
  localparam logic [9:0] VB_Y    = VB_LINE[9:0];

  logic [CHAR_W-1:0] shadow_char [6];
  logic [CHAR_W-1:0] active_char [6];
  logic [CHAR_W-1:0] shadow_char_nxt [6];
  logic [5:0]        shadow_blink, active_blink, shadow_blink_nxt;

  logic       prev_vb, vb, frame_tick;
  logic [2:0] hit_slot, sel;
  logic [2:0] slot_s1, bit_s1;
  logic       video_on_s1, blank_s1;

  function automatic logic in_cell(input logic [9:0] x, input logic [9:0] y,
                                   input logic [9:0] x0, input logic [9:0] y0);
    return (x >= x0) && (x <= x0 + 10'd15) && (y >= y0) && (y <= y0 + 10'd31);
  endfunction

  function automatic logic [CHAR_W-1:0] default_char(input int i);
    case (i)
      0:       return CHAR_W'(1);
      1, 2:    return CHAR_W'(2);
      3:       return CHAR_W'(3);
      4:       return CHAR_W'(4);
      default: return CHAR_W'(5);
    endcase
  endfunction

  // Priority chain gives the lowest slot precedence should cells ever overlap.
  always_comb begin
    hit_slot = NO_SLOT;
    if (video_on) begin
      if      (in_cell(pixel_x, pixel_y, 10'd96,  10'd64))  hit_slot = 3'd0;
      else if (in_cell(pixel_x, pixel_y, 10'd128, 10'd64))  hit_slot = 3'd1;
      else if (in_cell(pixel_x, pixel_y, 10'd64,  10'd224)) hit_slot = 3'd2;
      else if (in_cell(pixel_x, pixel_y, 10'd96,  10'd224)) hit_slot = 3'd3;
      else if (in_cell(pixel_x, pixel_y, 10'd96,  10'd384)) hit_slot = 3'd4;
      else if (in_cell(pixel_x, pixel_y, 10'd128, 10'd384)) hit_slot = 3'd5;
    end
  end

  assign sel        = (hit_slot == NO_SLOT) ? 3'd0 : hit_slot;
  assign vb         = (pixel_y >= VB_Y);
  assign frame_tick = vb & ~prev_vb;

  // Next shadow state also feeds the active copy, so a write on the tick cycle commits at once.
  always_comb begin
    shadow_char_nxt  = shadow_char;
    shadow_blink_nxt = shadow_blink;
    if (cfg_we && (cfg_slot < 3'd6)) begin
      shadow_char_nxt[cfg_slot]  = cfg_char;
      shadow_blink_nxt[cfg_slot] = cfg_blink;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        shadow_char[i] <= default_char(i);
        active_char[i] <= default_char(i);
      end
      shadow_blink <= '0;
      active_blink <= '0;
      prev_vb      <= 1'b1;
      frame_cnt    <= '0;
      rom_addr     <= '0;
      slot_s1      <= NO_SLOT;
      bit_s1       <= '0;
      video_on_s1  <= 1'b0;
      blank_s1     <= 1'b0;
      text_on      <= 1'b0;
      text_slot    <= NO_SLOT;
      video_on_d   <= 1'b0;
    end else begin
      shadow_char  <= shadow_char_nxt;
      shadow_blink <= shadow_blink_nxt;
      prev_vb      <= vb;
      if (frame_tick) begin
        active_char  <= shadow_char_nxt;
        active_blink <= shadow_blink_nxt;
        frame_cnt    <= frame_cnt + 5'd1;
      end

      rom_addr    <= (hit_slot == NO_SLOT) ? '0 : {active_char[sel], pixel_y[4:1]};
      slot_s1     <= hit_slot;
      bit_s1      <= pixel_x[3:1];
      video_on_s1 <= video_on;
      blank_s1    <= active_blink[sel] & frame_cnt[4];

      text_on    <= (slot_s1 != NO_SLOT) & rom_data[3'd7 - bit_s1] & ~blank_s1;
      text_slot  <= slot_s1;
      video_on_d <= video_on_s1;
    end
  end

endmodule

// File: tb/tb_vga_text_scheduler.sv
// tb/tb_vga_text_scheduler.sv - directed self-checking bench for vga_text_scheduler
module tb_vga_text_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       video_on;
  logic [9:0] pixel_x, pixel_y;
  logic       cfg_we;
  logic [2:0] cfg_slot;
  logic [5:0] cfg_char;
  logic       cfg_blink;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic       text_on;
  logic [2:0] text_slot;
  logic       video_on_d;
  logic [4:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit         rom_force  = 1'b0;
  logic [7:0] rom_forced = 8'h00;

  int m_act [6];
  int m_sh  [6];
  bit m_bl_act [6];
  bit m_bl_sh  [6];
  int m_frame;
  bit m_prev_vb;
  int p_slot, p_addr, p_bit;
  bit p_blank, p_von;

  int sweep_rows [14] = '{63, 64, 70, 95, 96, 223, 224, 255, 256, 383, 384, 415, 416, 479};
  int cx [6] = '{100, 130, 70, 100, 100, 130};
  int cy [6] = '{70, 70, 230, 230, 390, 390};
  int exp_code [6] = '{1, 2, 2, 3, 9, 5};

  vga_text_scheduler #(.CHAR_W(6), .VB_LINE(480)) dut (
    .clk(clk), .rst(rst), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_char(cfg_char), .cfg_blink(cfg_blink),
    .rom_addr(rom_addr), .rom_data(rom_data), .text_on(text_on), .text_slot(text_slot),
    .video_on_d(video_on_d), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_model(input logic [9:0] a);
    return (a[7:0] * 8'd37) ^ 8'hA5;
  endfunction

  assign rom_data = rom_force ? rom_forced : rom_model(rom_addr);

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int cell_of(input int x, input int y, input bit v);
    if (!v) return 7;
    if (y >= 64 && y <= 95) begin
      if (x >= 96 && x <= 111) return 0;
      if (x >= 128 && x <= 143) return 1;
    end
    if (y >= 224 && y <= 255) begin
      if (x >= 64 && x <= 79) return 2;
      if (x >= 96 && x <= 111) return 3;
    end
    if (y >= 384 && y <= 415) begin
      if (x >= 96 && x <= 111) return 4;
      if (x >= 128 && x <= 143) return 5;
    end
    return 7;
  endfunction

  task automatic model_reset();
    m_act = '{1, 2, 2, 3, 4, 5};
    m_sh  = '{1, 2, 2, 3, 4, 5};
    for (int i = 0; i < 6; i++) begin
      m_bl_act[i] = 1'b0;
      m_bl_sh[i]  = 1'b0;
    end
    m_frame   = 0;
    m_prev_vb = 1'b1;
    p_slot = 7; p_addr = 0; p_bit = 0; p_blank = 1'b0; p_von = 1'b0;
  endtask

  task automatic do_reset(input int x, input int y);
    rst = 1'b1; cfg_we = 1'b0; video_on = 1'b1;
    pixel_x = 10'(x); pixel_y = 10'(y);
    @(posedge clk); #1;
    check("rst_addr",  int'(rom_addr),   0);
    check("rst_on",    int'(text_on),    0);
    check("rst_slot",  int'(text_slot),  7);
    check("rst_von",   int'(video_on_d), 0);
    check("rst_frame", int'(frame_cnt),  0);
    rst = 1'b0;
    model_reset();
  endtask

  // One pixel per clock; checks rom_addr for this pixel and stage-2 outputs for the previous one.
  task automatic pix(input int x, input int y, input bit v);
    int s, a, exp_on;
    bit bl, vb, tick;
    logic [7:0] d;
    s  = cell_of(x, y, v);
    a  = (s == 7) ? 0 : m_act[s] * 16 + (y / 2) % 16;
    bl = (s != 7) && m_bl_act[s] && (m_frame >= 16);
    vb = (y >= 480);
    tick = vb && !m_prev_vb;
    m_prev_vb = vb;
    if (cfg_we && cfg_slot < 3'd6) begin
      m_sh[cfg_slot]    = int'(cfg_char);
      m_bl_sh[cfg_slot] = cfg_blink;
    end
    if (tick) begin
      m_act    = m_sh;
      m_bl_act = m_bl_sh;
      m_frame  = (m_frame + 1) % 32;
    end
    video_on = v; pixel_x = 10'(x); pixel_y = 10'(y);
    @(posedge clk); #1;
    d = rom_force ? rom_forced : rom_model(10'(p_addr));
    exp_on = (p_slot != 7 && d[7 - p_bit] && !p_blank) ? 1 : 0;
    check("sb_addr",  int'(rom_addr),   a);
    check("sb_on",    int'(text_on),    exp_on);
    check("sb_slot",  int'(text_slot),  p_slot);
    check("sb_von",   int'(video_on_d), int'(p_von));
    check("sb_frame", int'(frame_cnt),  m_frame);
    p_slot = s; p_addr = a; p_bit = (x / 2) % 8; p_blank = bl; p_von = v;
  endtask

  task automatic next_frame();
    pix(0, 479, 1'b1);
    pix(0, 480, 1'b1);
    pix(0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_slot = 3'd0; cfg_char = 6'd0; cfg_blink = 1'b0;
    video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    do_reset(0, 0);

    rom_force = 1'b1; rom_forced = 8'h80;
    pix(100, 70, 1'b1);
    check("dir_addr", int'(rom_addr), 'h013);
    pix(0, 0, 1'b1);
    check("dir_on_80", int'(text_on), 0);
    check("dir_slot",  int'(text_slot), 0);
    rom_forced = 8'h20;
    pix(100, 70, 1'b1);
    pix(0, 0, 1'b1);
    check("dir_on_20", int'(text_on), 1);

    pix(100, 70, 1'b0);
    pix(0, 0, 1'b1);
    check("vid_off_slot", int'(text_slot), 7);

    rom_force = 1'b0;
    foreach (sweep_rows[r]) begin
      for (int x = 0; x < 160; x++) pix(x, sweep_rows[r], 1'b1);
      pix(600, sweep_rows[r], 1'b1);
    end

    cfg_we = 1'b1; cfg_slot = 3'd4; cfg_char = 6'd9; cfg_blink = 1'b0;
    pix(0, 100, 1'b1);
    cfg_we = 1'b0;
    pix(100, 390, 1'b1);
    check("s4_old_code", int'(rom_addr[9:4]), 4);
    next_frame();
    pix(100, 390, 1'b1);
    check("s4_new_code", int'(rom_addr[9:4]), 9);

    cfg_we = 1'b1; cfg_slot = 3'd6; cfg_char = 6'd63; cfg_blink = 1'b1;
    pix(0, 100, 1'b1);
    cfg_slot = 3'd7; cfg_char = 6'd62;
    pix(0, 101, 1'b1);
    cfg_we = 1'b0;
    next_frame();
    next_frame();
    for (int s = 0; s < 6; s++) begin
      pix(cx[s], cy[s], 1'b1);
      check("bad_slot_code", int'(rom_addr[9:4]), exp_code[s]);
    end

    do_reset(0, 0);
    rom_force = 1'b1; rom_forced = 8'hFF;
    pix(0, 0, 1'b1);
    pix(0, 479, 1'b1);
    cfg_we = 1'b1; cfg_slot = 3'd1; cfg_char = 6'd2; cfg_blink = 1'b1;
    pix(0, 480, 1'b1);
    cfg_we = 1'b0;
    for (int f = 1; f <= 40; f++) begin
      pix(0, 0, 1'b1);
      pix(130, 70, 1'b1);
      pix(0, 0, 1'b1);
      check("blink_on",    int'(text_on),   int'((f % 32) < 16));
      check("blink_frame", int'(frame_cnt), f % 32);
      pix(0, 479, 1'b1);
      pix(0, 480, 1'b1);
    end
    check("blink_end_frame", int'(frame_cnt), 9);

    pix(0, 0, 1'b1);
    pix(130, 400, 1'b1);
    pix(130, 400, 1'b1);
    check("pre_rst_on",   int'(text_on),   1);
    check("pre_rst_slot", int'(text_slot), 5);
    do_reset(130, 400);
    do_reset(0, 490);
    pix(0, 490, 1'b1);
    pix(0, 491, 1'b1);
    check("no_tick_frame", int'(frame_cnt), 0);
    pix(0, 0, 1'b1);
    pix(0, 480, 1'b1);
    check("tick_after_rst", int'(frame_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_text_scheduler.md
# vga_text_scheduler

Sequences font-ROM accesses for the static text labels of the VGA clock overlay (date, hour and timer captions). For each incoming pixel it decides which label cell, if any, is being scanned and issues the glyph-row ROM address. It then realigns the ROM data with a delayed pixel stream to produce a per-pixel text-on flag. Label glyphs and blink enables are written through a shadow-register interface and committed at vertical-blank start, so captions never tear mid-frame.

## Interface
Parameters:
- CHAR_W, 6, glyph code width (64 glyphs); ROM address width is CHAR_W+4
- VB_LINE, 480, first pixel_y line of vertical blanking

Ports:
- clk  in  1  pixel clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- video_on  in  1  active-video flag from the sync generator
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- cfg_we  in  1  one-cycle shadow write strobe
- cfg_slot  in  3  label slot 0..5; values 6 and 7 are ignored
- cfg_char  in  CHAR_W  glyph code written to the slot
- cfg_blink  in  1  blink enable written to the slot
- rom_addr  out  CHAR_W+4  {glyph code, glyph row} to the font ROM, registered
- rom_data  in  8  font ROM row; valid 1 cycle after rom_addr
- text_on  out  1  glyph pixel lit, aligned 2 cycles after inputs
- text_slot  out  3  slot owning the pixel (7 = none), aligned with text_on
- video_on_d  out  1  video_on delayed 2 cycles
- frame_cnt  out  5  free-running frame counter

## Operation
Slot map. Each cell is 16x32 px (glyph 8x16, doubled), with inclusive bounds:
- slot 0: x 96..111, y 64..95
- slot 1: x 128..143, y 64..95
- slot 2: x 64..79, y 224..255
- slot 3: x 96..111, y 224..255
- slot 4: x 96..111, y 384..415
- slot 5: x 128..143, y 384..415
- Cells never overlap. If more than one cell matched, the lowest slot would win.

Stage 1 (registered):
- rom_addr = {active_char[slot], pixel_y[4:1]}.
- Latch slot_s1 (7 when no hit or video_on=0), bit_s1 = pixel_x[3:1], video_on_s1.
- With no hit, rom_addr = 0.

Stage 2 (registered):
- text_on = (slot_s1 != 7) & rom_data[7 - bit_s1] & ~blank_s1.
- blank_s1 = blink_en[slot] & frame_cnt[4].
- text_slot = slot_s1; video_on_d = video_on_s1.

Config:
- cfg_we with cfg_slot < 6 writes shadow_char and shadow_blink every cycle it is asserted. No backpressure.
- frame_tick = rising edge of (pixel_y >= VB_LINE), detected with a registered previous flag.
- On frame_tick: active registers <= shadow registers, and frame_cnt increments modulo 32.
- If cfg_we coincides with frame_tick, the new value lands in both shadow and active for that slot.

Reset values:
- shadow/active chars, slots 0..5 = 1, 2, 2, 3, 4, 5 (F, H, H, R, T, I); all blink = 0.
- rom_addr = 0, text_on = 0, text_slot = 7, video_on_d = 0, frame_cnt = 0.
- Pipeline slot regs = 7. prev_vb flag = 1, so no tick fires until the next genuine blank entry.

## Timing
- Latency is fixed at 2 cycles from pixel inputs to text_on/text_slot/video_on_d. The downstream colour mux must use the delayed flags.
- The ROM is assumed to have a 1-cycle registered read; rom_data is sampled in stage 2 only.
- A shadow write becomes visible at the first frame_tick after it. Pixels of the current frame are unaffected.
- Blink period is 32 frames: lit for 16, blank for 16. Blink does not alter rom_addr.
- Reset mid-frame: all outputs return to reset values the next cycle. The pipeline refills after 2 cycles of deasserted rst.
- video_on=0 forces slot 7 regardless of coordinates.

## Test plan
- Reset, then scan (100,70) with rom_data=0x80, pixel_x[3:1]=2: rom_addr={1, 3} one cycle later; text_on=0, text_slot=0 at +2. Repeat with rom_data=0x20: text_on=1.
- Full-frame sweep with a ROM model: text_on only inside the 6 cells. Default glyph codes appear on rom_addr; outside cells text_slot=7 and rom_addr=0.
- Write slot 4 char=9 mid-frame: rom_addr for the slot 4 cell keeps code 4 until the y=480 crossing, then shows code 9 next frame.
- Write with cfg_slot=6 or 7: no change in any slot over 2 frames.
- Enable blink on slot 1 and run 40 frames: text_on suppressed in frames 16..31 and lit in frames 0..15 and 32..39; frame_cnt wraps 31->0.
- Assert rst at pixel (130,400) during a lit glyph: text_on=0, text_slot=7, frame_cnt=0 next cycle. No frame_tick if rst releases while in blank.
